// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents:
//   - FSM state encoding
//   - bit positions of the RISC-V opcode/func fields inside an instruction word
//   - the canonical NOP (addi x0, x0, 0)
//   - the default reset PC
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNC3_LSB  = 12;
  localparam int FUNC3_MSB  = 14;
  localparam int FUNC7_LSB  = 25;
  localparam int FUNC7_MSB  = 31;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: 32-bit program counter register.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset, loads RESET_VAL
//   load  - when high, pc_q takes pc_d at the next edge
//   pc_d  - next PC value
//   pc_q  - current PC
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_VAL;
    end else if (load) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetch stage.
// Requests the word at PC, captures it into Instr, presents it to execute
// (instr_valid) until it is consumed (stall low), then advances PC to
// PC+4 or to the redirect target. Memory timeouts and misaligned redirect
// targets park the unit in HALT with a sticky fetch_err until reset.
// Ports:
//   clk, rst (sync, active-low)
//   imem_req/imem_addr out, imem_ack/imem_rdata in  - instruction memory
//   Instr, Opcode, func3, func7                      - fetched word + fields
//   instr_valid, PC, PCPlus4                         - to execute stage
//   PCSrc, PCTarget, stall                           - from control
//   fetch_err                                        - sticky error flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [6:0]  Opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        stall,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fetch_state_e  state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic [31:0]   instr_q, instr_d;
  // Low for the first cycle out of reset so the first request is issued
  // only after rst has been seen released at a clock edge.
  logic          started_q, started_d;

  logic          pc_load;
  logic [31:0]   pc_next;
  logic [31:0]   pc_q;
  logic [31:0]   pc_plus4;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .pc_d (pc_next),
    .pc_q (pc_q)
  );

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    instr_d   = instr_q;
    started_d = 1'b1;
    pc_load   = 1'b0;
    pc_next   = pc_plus4;

    case (state_q)
      ST_FETCH: begin
        if (started_q) begin
          // Ack is checked first so an ack on the timeout cycle still wins.
          if (imem_ack) begin
            instr_d = imem_rdata;
            wait_d  = '0;
            state_d = ST_EXEC;
          end else if (wait_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            wait_d = wait_q + CW'(1);
          end
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_load = 1'b1;
            pc_next = PCSrc ? PCTarget : pc_plus4;
            wait_d  = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      err_q     <= 1'b0;
      instr_q   <= NOP_INSTR;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      instr_q   <= instr_d;
      started_q <= started_d;
    end
  end

  assign imem_req    = started_q && (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign fetch_err   = err_q;
  assign Instr       = instr_q;
  assign Opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign func3       = instr_q[FUNC3_MSB:FUNC3_LSB];
  assign func7       = instr_q[FUNC7_MSB:FUNC7_LSB];
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [6:0]  Opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        stall;
  logic        fetch_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .Opcode      (Opcode),
    .func3       (func3),
    .func7       (func7),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .stall       (stall),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic do_advance(input logic src, input logic [31:0] tgt);
    PCSrc    = src;
    PCTarget = tgt;
    tick();
    PCSrc    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    PCSrc = 1'b0; PCTarget = '0; stall = 1'b0;
    tick(); tick();
    chk_cnt++; if (Instr !== 32'h13) $display("FAIL reset_instr got %h want %h", Instr, 32'h13); else pass_cnt++;
    chk_cnt++; if (PC !== 32'h0) $display("FAIL reset_pc got %h want %h", PC, 32'h0); else pass_cnt++;
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else pass_cnt++;
    chk_cnt++; if (fetch_err !== 1'b0) $display("FAIL reset_err got %b want 0", fetch_err); else pass_cnt++;
    rst = 1'b1;
    #2;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL req_before_edge got %b want 0", imem_req); else pass_cnt++;
    tick();
    chk_cnt++; if (imem_req !== 1'b1) $display("FAIL req_after_release got %b want 1", imem_req); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL first_addr got %h want %h", imem_addr, 32'h0); else pass_cnt++;
  endtask

  task automatic test_first_fetch();
    do_fetch(32'h0050_0093);
    chk_cnt++; if (instr_valid !== 1'b1) $display("FAIL ff_valid got %b want 1", instr_valid); else pass_cnt++;
    chk_cnt++; if (Instr !== 32'h0050_0093) $display("FAIL ff_instr got %h want %h", Instr, 32'h0050_0093); else pass_cnt++;
    chk_cnt++; if (Opcode !== 7'h13) $display("FAIL ff_opcode got %h want %h", Opcode, 7'h13); else pass_cnt++;
    chk_cnt++; if (func3 !== 3'h0 || func7 !== 7'h0) $display("FAIL ff_funcs got %h/%h want 0/0", func3, func7); else pass_cnt++;
    chk_cnt++; if (PC !== 32'h0) $display("FAIL ff_pc got %h want %h", PC, 32'h0); else pass_cnt++;
    chk_cnt++; if (PCPlus4 !== 32'h4) $display("FAIL ff_pcplus4 got %h want %h", PCPlus4, 32'h4); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL ff_req_dropped got %b want 0", imem_req); else pass_cnt++;
  endtask

  task automatic test_redirect();
    do_advance(1'b1, 32'h10);
    chk_cnt++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) $display("FAIL redir_10 got %h/%b want %h/1", imem_addr, imem_req, 32'h10); else pass_cnt++;
    do_fetch(32'h0000_0033);
    chk_cnt++; if (PC !== 32'h10 || PCPlus4 !== 32'h14) $display("FAIL exec_pc10 got %h/%h want %h/%h", PC, PCPlus4, 32'h10, 32'h14); else pass_cnt++;
    do_advance(1'b1, 32'h40);
    chk_cnt++; if (imem_addr !== 32'h40) $display("FAIL redir_40 got %h want %h", imem_addr, 32'h40); else pass_cnt++;
    do_fetch(32'h0000_0033);
    do_advance(1'b1, 32'h10);
    do_fetch(32'h0000_0033);
    do_advance(1'b0, 32'h40);
    chk_cnt++; if (imem_addr !== 32'h14) $display("FAIL seq_14 got %h want %h", imem_addr, 32'h14); else pass_cnt++;
    do_fetch(32'h0000_0033);
  endtask

  task automatic test_wrap();
    do_advance(1'b1, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013);
    chk_cnt++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) $display("FAIL wrap_pc got %h/%h want %h/%h", PC, PCPlus4, 32'hFFFF_FFFC, 32'h0); else pass_cnt++;
    do_advance(1'b0, 32'h0);
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h want %h", imem_addr, 32'h0); else pass_cnt++;
    do_fetch(32'h0020_81B3);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || PC !== 32'h0 || Instr !== 32'h0020_81B3)
        $display("FAIL stall_hold got v=%b r=%b pc=%h i=%h want v=1 r=0 pc=%h i=%h",
                 instr_valid, imem_req, PC, Instr, 32'h0, 32'h0020_81B3);
      else pass_cnt++;
    end
    stall = 1'b0;
    tick();
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL stall_release got %b/%h want 1/%h", imem_req, imem_addr, 32'h4); else pass_cnt++;
  endtask

  task automatic test_ack_at_limit();
    repeat (14) tick();
    chk_cnt++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) $display("FAIL wait14 got err=%b req=%b want 0/1", fetch_err, imem_req); else pass_cnt++;
    do_fetch(32'h4000_0033);
    chk_cnt++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) $display("FAIL ack_wins got v=%b err=%b want 1/0", instr_valid, fetch_err); else pass_cnt++;
    chk_cnt++; if (func7 !== 7'h20 || Opcode !== 7'h33) $display("FAIL slice_f7 got %h/%h want %h/%h", func7, Opcode, 7'h20, 7'h33); else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_advance(1'b0, 32'h0);
    repeat (14) tick();
    chk_cnt++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) $display("FAIL to_pre got err=%b req=%b want 0/1", fetch_err, imem_req); else pass_cnt++;
    tick();
    chk_cnt++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL to_halt got err=%b req=%b v=%b want 1/0/0", fetch_err, imem_req, instr_valid); else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    repeat (3) tick();
    imem_ack = 1'b0;
    chk_cnt++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || Instr !== 32'h4000_0033) $display("FAIL halt_ack got err=%b v=%b i=%h want 1/0/%h", fetch_err, instr_valid, Instr, 32'h4000_0033); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    do_reset();
    chk_cnt++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) $display("FAIL reset_clears got err=%b req=%b want 0/1", fetch_err, imem_req); else pass_cnt++;
    do_fetch(32'h0000_0013);
    do_advance(1'b1, 32'h42);
    chk_cnt++; if (fetch_err !== 1'b1 || PC !== 32'h0) $display("FAIL misalign got err=%b pc=%h want 1/%h", fetch_err, PC, 32'h0); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL misalign_halt got req=%b v=%b want 0/0", imem_req, instr_valid); else pass_cnt++;
  endtask

  task automatic test_reset_during_fetch();
    do_reset();
    do_fetch(32'h0000_0033);
    do_advance(1'b0, 32'h0);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL rdf_pre got %b/%h want 1/%h", imem_req, imem_addr, 32'h4); else pass_cnt++;
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk_cnt++; if (Instr !== 32'h13 || PC !== 32'h0 || instr_valid !== 1'b0) $display("FAIL rdf_state got i=%h pc=%h v=%b want %h/%h/0", Instr, PC, instr_valid, 32'h13, 32'h0); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rdf_req got %b want 0", imem_req); else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rdf_restart got %b/%h want 1/%h", imem_req, imem_addr, 32'h0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_redirect();
    test_wrap();
    test_stall();
    test_ack_at_limit();
    test_timeout();
    test_misaligned();
    test_reset_during_fetch();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for imem_ack before a fetch error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request, held high until acknowledged.
REQ-006 imem_addr  output  32  word-aligned fetch address, equals PC while imem_req is high.
REQ-007 imem_ack  input  1  memory has returned imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word, sampled only when imem_req and imem_ack are both high.
REQ-009 Instr  output  32  registered instruction word.
REQ-010 Opcode  output  7  Instr[6:0].
REQ-011 func3  output  3  Instr[14:12].
REQ-012 func7  output  7  Instr[31:25].
REQ-013 instr_valid  output  1  Instr is valid for execution this cycle.
REQ-014 PC / PCPlus4  output  32 each  address of Instr, and PC+4.
REQ-015 PCSrc  input  1  redirect taken, from control unit; sampled only when instr_valid is high.
REQ-016 PCTarget  input  32  branch/jump target; sampled with PCSrc.
REQ-017 stall  input  1  hold the current instruction; no PC advance.
REQ-018 fetch_err  output  1  sticky: misaligned target or memory timeout.

Function
REQ-019 FSM states: FETCH (imem_req=1), EXEC (instr_valid=1), HALT (fetch_err=1, no requests).
REQ-020 FETCH: on imem_ack, capture imem_rdata into Instr and move to EXEC; otherwise stay, and increment the wait counter.
REQ-021 FETCH: when the wait counter reaches TIMEOUT without imem_ack, set fetch_err and move to HALT.
REQ-022 EXEC with stall=1: stay in EXEC; Instr and PC hold.
REQ-023 EXEC with stall=0:
  - PC <= PCTarget if PCSrc=1, else PCPlus4.
  - Move to FETCH; clear the wait counter.
REQ-024 If PCSrc=1 and PCTarget[1:0]!=0: PC holds, fetch_err is set, move to HALT.
REQ-025 Latency: instr_valid is asserted the cycle after imem_ack; minimum 2 cycles per instruction.
REQ-026 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-027 imem_addr and imem_req are stable from assertion until imem_ack.
REQ-028 If imem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins: no error.
REQ-029 HALT is left only by reset; imem_ack while in HALT is ignored.
REQ-030 Opcode, func3 and func7 are pure slices of Instr; they are never decoded here.

Reset
REQ-031 With rst=0 at a clock edge:
  - PC=RESET_PC, Instr=32'h0000_0013 (NOP);
  - instr_valid=0, imem_req=0, fetch_err=0;
  - wait counter=0, state goes to FETCH.
REQ-032 A reset during FETCH abandons the outstanding request; an ack arriving in the same cycle is discarded.
REQ-033 imem_req first asserts the cycle after rst is released.

Structure
REQ-034 A shared package holds:
  - the FSM state encoding;
  - opcode field bit positions;
  - the NOP constant;
  - the RESET_PC default.
REQ-035 One sub-module, pc_reg: a 32-bit PC register with load enable and synchronous reset value.

Verification
REQ-036 Reset release, memory acks in 1 cycle returning 32'h00500093 -> imem_addr=0; next cycle instr_valid=1, Opcode=7'h13, PC=0, PCPlus4=4.
REQ-037 PC=0x10, PCSrc=1, PCTarget=0x40 during EXEC -> next imem_addr=0x40; with PCSrc=0 instead -> next imem_addr=0x14.
REQ-038 Hold imem_ack low for 15 cycles -> fetch_err=1, imem_req=0, state HALT; a later ack has no effect.
REQ-039 PCSrc=1, PCTarget=0x42 -> fetch_err=1, PC holds.
REQ-040 stall=1 for 3 cycles in EXEC -> Instr and PC stable, no imem_req; stall drops -> advance.
REQ-041 rst=0 asserted during FETCH with ack in the same cycle -> Instr=NOP, PC=RESET_PC, instr_valid=0.
